ym2149_bus_ctrl: RTL and testbench

Two-requester arbiter and bus sequencer for the ym2149 PSG register interface. It accepts register read/write transactions from the CPU port (R0) and the music-player/DMA port (R1), arbitrates between them round-robin, and drives BDIR/BC/data. The ym2149 needs two BDIR rising edges per write: an address latch, then a data write. Sits between the system bus glue and the ym2149 instance; the ym2149 runs on the same CLK.

---
 rtl/ym2149_bus_pkg.sv | 32 +++
 rtl/ym2149_rr_arb.sv | 58 +++++
 rtl/ym2149_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_ym2149_bus_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym2149_bus_pkg.sv
// Shared types and constants for the ym2149 bus controller slice.
// Used by ym2149_rr_arb and ym2149_bus_ctrl.
package ym2149_bus_pkg;

    // Sequencer states. The encoding is only used internally.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        GAP1  = 3'd2,
        DATA  = 3'd3,
        RDSTB = 3'd4,
        GAP2  = 3'd5,
        DONE  = 3'd6
    } bus_state_t;

    // Register numbers that benches use.
    localparam logic [3:0] YM_REG_MIXER     = 4'd7;
    localparam logic [3:0] YM_REG_ENV_SHAPE = 4'd13;

    // Transaction captured at grant time.
    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
    } psg_txn_t;

    // Terminal value of the 4-bit phase counter for a phase of 'width' cycles.
    function automatic logic [3:0] phase_last(input int unsigned width);
        return 4'(width - 32'd1);
    endfunction

endpackage

// File: rtl/ym2149_rr_arb.sv
// Two-way round-robin arbiter for the ym2149 bus controller.
// gnt is the one-hot candidate for the current request vector. The owner is
// recorded when the sequencer accepts a grant, and priority moves to the
// other requester when that transaction reports done.
module ym2149_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    input  logic       done,
    output logic [1:0] gnt
);
    import ym2149_bus_pkg::*;

    logic prio_q;   // 1: requester 1 wins a tie
    logic prio_d;
    logic owner_q;
    logic owner_d;

    // Pick the winner from the request vector and the tie-break priority.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the owner at accept, and hand priority to the other side at done.
    always_comb begin
        owner_d = owner_q;
        prio_d  = prio_q;
        if (accept) begin
            owner_d = gnt[1];
        end else begin
            owner_d = owner_q;
        end
        if (done) begin
            prio_d = ~owner_q;
        end else begin
            prio_d = prio_q;
        end
    end

    // Arbiter state registers. After reset requester 0 wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            prio_q  <= prio_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: rtl/ym2149_bus_ctrl.sv
// Two-requester arbiter and bus sequencer for the ym2149 PSG register port.
// A write is an address-latch pulse followed by a data-write pulse. A read is
// an address-latch pulse followed by a read strobe. Each pulse is followed by
// an idle gap.
// Optional feature: define YM_ADDR_CACHE_EN to skip the address phase when
// the PSG already holds the requested register address.
module ym2149_bus_ctrl #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       R0_REQ,
    input  logic       R0_WE,
    input  logic [3:0] R0_ADDR,
    input  logic [7:0] R0_WDATA,
    output logic       R0_ACK,
    output logic [7:0] R0_RDATA,
    input  logic       R1_REQ,
    input  logic       R1_WE,
    input  logic [3:0] R1_ADDR,
    input  logic [7:0] R1_WDATA,
    output logic       R1_ACK,
    output logic [7:0] R1_RDATA,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] PSG_DI,
    input  logic [7:0] PSG_DO,
    output logic       BUSY
);
    import ym2149_bus_pkg::*;

    localparam logic [3:0] PULSE_LAST = phase_last(PULSE_W);
    localparam logic [3:0] GAP_LAST   = phase_last(GAP_W);

    bus_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    psg_txn_t   txn_q, txn_d;
    logic       owner_q, owner_d;

    logic       bdir_q, bdir_d;
    logic       bc_q, bc_d;
    logic [7:0] di_q, di_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       busy_q, busy_d;

    logic [1:0] req_s;
    logic [1:0] gnt_s;
    logic       accept_s;
    logic       done_s;

`ifdef YM_ADDR_CACHE_EN
    logic [3:0] cache_addr_q, cache_addr_d;
    logic       cache_vld_q, cache_vld_d;
`endif

    assign req_s    = {R1_REQ, R0_REQ};
    assign accept_s = (state_q == IDLE) && (|req_s);
    assign done_s   = (state_q == DONE);

    ym2149_rr_arb u_arb (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .req    (req_s),
        .accept (accept_s),
        .done   (done_s),
        .gnt    (gnt_s)
    );

    // Next-state logic: grant and capture in IDLE, then step through the phases.
    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (gnt_s[1]) begin
                    owner_d = 1'b1;
                    txn_d   = '{we: R1_WE, addr: R1_ADDR, wdata: R1_WDATA};
                end else if (gnt_s[0]) begin
                    owner_d = 1'b0;
                    txn_d   = '{we: R0_WE, addr: R0_ADDR, wdata: R0_WDATA};
                end else begin
                    owner_d = owner_q;
                    txn_d   = txn_q;
                end
                if (|gnt_s) begin
`ifdef YM_ADDR_CACHE_EN
                    if (cache_vld_q && (cache_addr_q == txn_d.addr)) begin
                        state_d = txn_d.we ? DATA : RDSTB;
                    end else begin
                        state_d = ADDR;
                    end
`else
                    state_d = ADDR;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (cnt_q == PULSE_LAST) state_d = GAP1;
                else                     state_d = ADDR;
            end
            GAP1: begin
                if (cnt_q == GAP_LAST) state_d = txn_q.we ? DATA : RDSTB;
                else                   state_d = GAP1;
            end
            DATA: begin
                if (cnt_q == PULSE_LAST) state_d = GAP2;
                else                     state_d = DATA;
            end
            RDSTB: begin
                if (cnt_q == PULSE_LAST) state_d = GAP2;
                else                     state_d = RDSTB;
            end
            GAP2: begin
                if (cnt_q == GAP_LAST) state_d = DONE;
                else                   state_d = GAP2;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase counter restarts on every state change and counts within a phase.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Bus and handshake outputs, precomputed from the next state so the pins
    // change together with the state register.
    always_comb begin
        bdir_d   = 1'b0;
        bc_d     = 1'b0;
        di_d     = 8'h00;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        busy_d   = (state_d != IDLE);
        case (state_d)
            ADDR: begin
                bdir_d = 1'b1;
                bc_d   = 1'b1;
                di_d   = {4'b0000, txn_d.addr};
            end
            DATA: begin
                bdir_d = 1'b1;
                di_d   = txn_d.wdata;
            end
            RDSTB: begin
                bc_d = 1'b1;
            end
            DONE: begin
                ack0_d = ~owner_d;
                ack1_d = owner_d;
            end
            default: begin
                bdir_d = 1'b0;
            end
        endcase
        // Capture PSG_DO on the final strobe cycle for the owning requester only.
        if ((state_q == RDSTB) && (cnt_q == PULSE_LAST)) begin
            if (owner_q) rdata1_d = PSG_DO;
            else         rdata0_d = PSG_DO;
        end else begin
            rdata0_d = rdata0_q;
        end
    end

`ifdef YM_ADDR_CACHE_EN
    // Track the address most recently latched into the PSG.
    always_comb begin
        if (state_q == ADDR) begin
            cache_addr_d = txn_q.addr;
            cache_vld_d  = 1'b1;
        end else begin
            cache_addr_d = cache_addr_q;
            cache_vld_d  = cache_vld_q;
        end
    end

    // Address cache registers, cleared by reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cache_addr_q <= 4'd0;
            cache_vld_q  <= 1'b0;
        end else begin
            cache_addr_q <= cache_addr_d;
            cache_vld_q  <= cache_vld_d;
        end
    end
`endif

    // Sequencer state, phase counter and captured transaction.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            txn_q   <= '{we: 1'b0, addr: 4'd0, wdata: 8'h00};
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txn_q   <= txn_d;
            owner_q <= owner_d;
        end
    end

    // Registered output pins.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bdir_q   <= 1'b0;
            bc_q     <= 1'b0;
            di_q     <= 8'h00;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            bdir_q   <= bdir_d;
            bc_q     <= bc_d;
            di_q     <= di_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign BDIR     = bdir_q;
    assign BC       = bc_q;
    assign PSG_DI   = di_q;
    assign R0_ACK   = ack0_q;
    assign R1_ACK   = ack1_q;
    assign R0_RDATA = rdata0_q;
    assign R1_RDATA = rdata1_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_ym2149_bus_ctrl.sv
// Scoreboard bench for ym2149_bus_ctrl with a behavioural PSG register file.
// Honours YM_ADDR_CACHE_EN when the design is built with it.
module tb_ym2149_bus_ctrl;
    import ym2149_bus_pkg::*;

    localparam int PW = 2;
    localparam int GW = 1;
`ifdef YM_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       R0_REQ, R0_WE, R1_REQ, R1_WE;
    logic [3:0] R0_ADDR, R1_ADDR;
    logic [7:0] R0_WDATA, R1_WDATA;
    logic       R0_ACK, R1_ACK, BDIR, BC, BUSY;
    logic [7:0] R0_RDATA, R1_RDATA, PSG_DI, PSG_DO;

    // second instance with a short pulse and long gap
    logic       q0_req, q0_we, q0_ack, q1_ack, q_bdir, q_bc, q_busy;
    logic [3:0] q0_addr;
    logic [7:0] q0_wdata, q0_rdata, q1_rdata, q_di;
    logic [7:0] q_do = 8'h5A;
    logic       q1_req = 1'b0, q1_we = 1'b0;
    logic [3:0] q1_addr = 4'd0;
    logic [7:0] q1_wdata = 8'h00;

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    ym2149_bus_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA),
        .R0_ACK(R0_ACK), .R0_RDATA(R0_RDATA),
        .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA),
        .R1_ACK(R1_ACK), .R1_RDATA(R1_RDATA),
        .BDIR(BDIR), .BC(BC), .PSG_DI(PSG_DI), .PSG_DO(PSG_DO), .BUSY(BUSY)
    );

    ym2149_bus_ctrl #(.PULSE_W(1), .GAP_W(3)) dut2 (
        .CLK(CLK), .RESET_N(RESET_N),
        .R0_REQ(q0_req), .R0_WE(q0_we), .R0_ADDR(q0_addr), .R0_WDATA(q0_wdata),
        .R0_ACK(q0_ack), .R0_RDATA(q0_rdata),
        .R1_REQ(q1_req), .R1_WE(q1_we), .R1_ADDR(q1_addr), .R1_WDATA(q1_wdata),
        .R1_ACK(q1_ack), .R1_RDATA(q1_rdata),
        .BDIR(q_bdir), .BC(q_bc), .PSG_DI(q_di), .PSG_DO(q_do), .BUSY(q_busy)
    );

    // Implemented bits of each PSG register.
    function automatic logic [7:0] reg_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
            default:                 return 8'hFF;
        endcase
    endfunction

    // Behavioural PSG: latch address on BDIR&BC, write on BDIR&!BC.
    logic [7:0] psg_reg [16] = '{default: 8'h00};
    logic [3:0] psg_lat = 4'd0;
    always @(posedge CLK) begin
        if (BDIR && BC) psg_lat <= PSG_DI[3:0];
        else if (BDIR && !BC) psg_reg[psg_lat] <= PSG_DI & reg_mask(psg_lat);
    end
    assign PSG_DO = psg_reg[psg_lat];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Transaction-level reference model.
    typedef struct {
        int         port;
        bit         we;
        logic [7:0] rdata;
        logic [7:0] hold;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    logic [7:0] shadow [16] = '{default: 8'h00};
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    int         rr_last = 1;
    bit         cv = 1'b0;
    logic [3:0] ca = 4'd0;

    task automatic model_reset();
        rr_last    = 1;
        cv         = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
    endtask

    // Predict one transaction granted at t_grant; push its expected ACK.
    task automatic predict(input int p, input bit we, input logic [3:0] a,
                           input logic [7:0] wd, input int t_grant, output int t_ack);
        exp_t e;
        bit   hit;
        hit = CACHE && cv && (ca == a);
        if (!hit) begin
            cv = 1'b1;
            ca = a;
        end
        e.port  = p;
        e.we    = we;
        e.rdata = 8'h00;
        e.cyc   = t_grant + (hit ? (1 + PW + GW) : (1 + 2 * PW + 2 * GW));
        if (we) shadow[a] = wd & reg_mask(a);
        else begin
            e.rdata    = shadow[a];
            last_rd[p] = shadow[a];
        end
        e.hold  = last_rd[1 - p];
        rr_last = p;
        t_ack   = e.cyc;
        sbq.push_back(e);
    endtask

    // Monitor: pop and compare whenever an ACK appears.
    always @(negedge CLK) begin
        if (RESET_N && (R0_ACK || R1_ACK)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {30'd0, R1_ACK, R0_ACK}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("ack_port", {30'd0, R1_ACK, R0_ACK}, (mon_e.port == 1) ? 32'd2 : 32'd1);
                chk("ack_cycle", cyc, mon_e.cyc);
                chk("busy_at_ack", {31'd0, BUSY}, 32'd1);
                if (!mon_e.we)
                    chk("rdata", (mon_e.port == 1) ? R1_RDATA : R0_RDATA, mon_e.rdata);
                chk("other_rdata_hold", (mon_e.port == 1) ? R0_RDATA : R1_RDATA, mon_e.hold);
            end
        end
    end

    // One round: the selected ports request together from an IDLE cycle.
    task automatic round(input bit u0, input bit u1,
                         input bit we0, input logic [3:0] a0, input logic [7:0] d0,
                         input bit we1, input logic [3:0] a1, input logic [7:0] d1,
                         input bit mess, input bit wave);
        int t, first, ta, tb2, rel;
        bit got0, got1;
        @(posedge CLK); #1;
        t     = cyc;
        first = (u0 && u1) ? (1 - rr_last) : (u1 ? 1 : 0);
        if (first == 0) predict(0, we0, a0, d0, t, ta);
        else            predict(1, we1, a1, d1, t, ta);
        if (u0 && u1) begin
            if (first == 0) predict(1, we1, a1, d1, ta + 1, tb2);
            else            predict(0, we0, a0, d0, ta + 1, tb2);
        end
        R0_REQ = u0; R0_WE = we0; R0_ADDR = a0; R0_WDATA = d0;
        R1_REQ = u1; R1_WE = we1; R1_ADDR = a1; R1_WDATA = d1;
        got0 = !u0;
        got1 = !u1;
        for (int k = 0; k < 40 && !(got0 && got1); k++) begin
            @(posedge CLK); #1;
            rel = cyc - t;
            if (wave && rel >= 1 && rel <= 6) begin
                chk("wave_bdir", {31'd0, BDIR}, (rel == 1 || rel == 2 || rel == 4 || rel == 5) ? 32'd1 : 32'd0);
                chk("wave_bc", {31'd0, BC}, (rel == 1 || rel == 2) ? 32'd1 : 32'd0);
                if (rel == 1 || rel == 2) chk("wave_di_addr", PSG_DI, {4'h0, a0});
                if (rel == 4 || rel == 5) chk("wave_di_data", PSG_DI, d0);
            end
            if (mess && rel == 1) begin
                if (first == 0) begin
                    R0_WE = 1'($urandom); R0_ADDR = 4'($urandom); R0_WDATA = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) R0_REQ = 1'b0;
                end else begin
                    R1_WE = 1'($urandom); R1_ADDR = 4'($urandom); R1_WDATA = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) R1_REQ = 1'b0;
                end
            end
            if (R0_ACK) begin R0_REQ = 1'b0; got0 = 1'b1; end
            if (R1_ACK) begin R1_REQ = 1'b0; got1 = 1'b1; end
        end
        if (!(got0 && got1)) chk("ack_timeout", {30'd0, got1, got0}, {30'd0, u1, u0});
        R0_REQ = 1'b0;
        R1_REQ = 1'b0;
    endtask

    task automatic rand_round(input int mode, input bit mess);
        round(mode != 1, mode != 0,
              1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
              1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom), mess, 1'b0);
    endtask

    // Reset asserted in the first DATA cycle of a reg-8 write.
    task automatic reset_test();
        int t, ds;
        @(posedge CLK); #1;
        t  = cyc;
        ds = (CACHE && cv && ca == 4'd8) ? 1 : (1 + PW + GW);
        R0_REQ = 1'b1; R0_WE = 1'b1; R0_ADDR = 4'd8; R0_WDATA = 8'h77;
        while (cyc < t + ds) begin @(posedge CLK); #1; end
        chk("rst_bdir_in_data", {31'd0, BDIR}, 32'd1);
        chk("rst_bc_in_data", {31'd0, BC}, 32'd0);
        RESET_N = 1'b0;
        #1;
        chk("rst_bdir_now", {31'd0, BDIR}, 32'd0);
        chk("rst_busy_now", {31'd0, BUSY}, 32'd0);
        R0_REQ = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_no_ack", {30'd0, R1_ACK, R0_ACK}, 32'd0);
        chk("rst_r0_rdata", R0_RDATA, 8'h00);
        chk("rst_r1_rdata", R1_RDATA, 8'h00);
        RESET_N = 1'b1;
        model_reset();
    endtask

    // PULSE_W=1, GAP_W=3 instance: one write, pulse widths and ACK latency.
    task automatic pw_test();
        int t, run, npulse;
        bit got;
        run = 0; npulse = 0; got = 1'b0;
        @(posedge CLK); #1;
        t = cyc;
        q0_req = 1'b1; q0_we = 1'b1; q0_addr = 4'd3; q0_wdata = 8'h0C;
        for (int k = 0; k < 30 && !got; k++) begin
            @(posedge CLK); #1;
            if (q_bdir) run++;
            else if (run > 0) begin
                chk("pw1_pulse_width", run, 32'd1);
                npulse++;
                run = 0;
            end
            if (q0_ack) begin
                got = 1'b1;
                q0_req = 1'b0;
                chk("pw1_ack_cycle", cyc - t, 32'd9);
            end
        end
        if (!got) chk("pw1_ack_timeout", 32'd0, 32'd1);
        chk("pw1_pulse_count", npulse, 32'd2);
        q0_req = 1'b0;
    endtask

    initial begin
        R0_REQ = 1'b0; R0_WE = 1'b0; R0_ADDR = 4'd0; R0_WDATA = 8'h00;
        R1_REQ = 1'b0; R1_WE = 1'b0; R1_ADDR = 4'd0; R1_WDATA = 8'h00;
        q0_req = 1'b0; q0_we = 1'b0; q0_addr = 4'd0; q0_wdata = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_bdir", {31'd0, BDIR}, 32'd0);
        chk("reset_bc", {31'd0, BC}, 32'd0);
        chk("reset_di", PSG_DI, 8'h00);
        chk("reset_ack", {30'd0, R1_ACK, R0_ACK}, 32'd0);
        chk("reset_rdata", {R1_RDATA, R0_RDATA}, 16'h0000);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        RESET_N = 1'b1;

        // R0 writes mixer = 38 with waveform check, then reads it back.
        round(1'b1, 1'b0, 1'b1, YM_REG_MIXER, 8'h38, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
        round(1'b1, 1'b0, 1'b0, YM_REG_MIXER, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        chk("psg_reg7", psg_reg[7], 8'h38);
        // R1 writes A5 to reg 1, reads back the implemented nibble.
        round(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 8'hA5, 1'b0, 1'b0);
        round(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0);
        // Both ports requesting continuously.
        repeat (3) rand_round(2, 1'b0);
        repeat (40) rand_round(int'($urandom_range(0, 2)), 1'b1);
        // Back-to-back writes to reg 8 after moving the address elsewhere.
        round(1'b1, 1'b0, 1'b1, 4'd0, 8'h11, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        round(1'b1, 1'b0, 1'b1, 4'd8, 8'h0F, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        round(1'b1, 1'b0, 1'b1, 4'd8, 8'h1F, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        reset_test();
        round(1'b1, 1'b0, 1'b1, 4'd8, 8'h1F, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        round(1'b1, 1'b1, 1'b0, 4'd8, 8'h00, 1'b0, YM_REG_ENV_SHAPE, 8'h00, 1'b0, 1'b0);
        pw_test();

        repeat (4) @(posedge CLK);
        #1;
        chk("scoreboard_drain", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
